// File: rtl/mod_updown_counter_pkg.sv
// Shared encodings for the modulo up/down counter family.
// Imported by the counter top, its next-state logic and the users of either.
package mod_updown_counter_pkg;

  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter; master drives controls, slave returns count and flags.
// Pure wiring, no latency and no backpressure.
interface mod_updown_counter_if #(
  parameter int WIDTH = 2
);

  logic             en;
  logic             sclr;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, sclr, up_dn, load, din,
    input  count, tc, ovf
  );

  modport slave (
    input  en, sclr, up_dn, load, din,
    output count, tc, ovf
  );

endinterface

// File: rtl/mod_updown_counter_next.sv
// Combinational advance value and terminal-count detect for a modulo-MOD counter.
// Zero latency; no backpressure, the caller decides whether the advance is taken.
module mod_counter_next
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int MOD   = 4,
  parameter int MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_dn_i,
  input  logic             adv_i,
  output logic [WIDTH-1:0] count_nxt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

  logic in_range;
  logic at_term;

  // A full-range modulus cannot hold an out-of-range value, so skip the compare.
  if (MOD >= (1 << WIDTH)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (count_i <= TOP);
  end

  always_comb begin
    at_term     = 1'b0;
    count_nxt_o = '0;
    if (in_range) begin
      if (up_dn_i == UP) begin
        at_term     = (count_i == TOP);
        count_nxt_o = at_term ? ((MODE == MODE_SAT) ? TOP : '0)
                              : count_i + WIDTH'(1);
      end else begin
        at_term     = (count_i == '0);
        count_nxt_o = at_term ? ((MODE == MODE_SAT) ? '0 : TOP)
                              : count_i - WIDTH'(1);
      end
    end
    tc_o = adv_i & at_term;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with sync clear, clamped load, wrap/saturate and sticky overflow.
// One clk1 edge from any control to count; always accepts, no backpressure.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int MOD   = 4,
  parameter int MODE  = MODE_WRAP
) (
  input  logic                  clk1,
  input  logic                  clr_n,
  mod_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("mod_updown_counter: MOD=%0d illegal for WIDTH=%0d", MOD, WIDTH);
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] din_clamped;
  logic             ovf_q, ovf_d;
  logic             adv;
  logic             tc;

  assign adv = bus.en & ~bus.sclr & ~bus.load;

  if (MOD >= (1 << WIDTH)) begin : g_no_clamp
    assign din_clamped = bus.din;
  end else begin : g_clamp
    assign din_clamped = (bus.din > TOP) ? TOP : bus.din;
  end

  mod_counter_next #(
    .WIDTH (WIDTH),
    .MOD   (MOD),
    .MODE  (MODE)
  ) u_next (
    .count_i     (count_q),
    .up_dn_i     (bus.up_dn),
    .adv_i       (adv),
    .count_nxt_o (count_nxt),
    .tc_o        (tc)
  );

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q | tc;
    if (bus.sclr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      count_d = din_clamped;
    end else if (bus.en) begin
      count_d = count_nxt;
    end
  end

  always_ff @(posedge clk1 or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc;
  assign bus.ovf   = ovf_q;

endmodule
